mem_access_unit: RTL and testbench

CPU-side initiator for the unified 256-word instruction/data memory of the multi-cycle MIPS core. It accepts instruction-fetch and load/store requests from the control unit and arbitrates between them. It drives the memory's Address/Write_data/MemRead/MemWrite port and registers the returned Mem_data into an instruction register (fetch) or a data register (load). A req/ack handshake hides memory latency from the control FSM.

---
 rtl/mem_access_unit_pkg.sv | 23 ++
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Holds the FSM state encoding, the client select encoding, the
// word-alignment mask and a small alignment helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    CLI_FETCH = 1'b0,
    CLI_DATA  = 1'b1
  } client_e;

  localparam logic [1:0] WORD_ALIGN = 2'b00;

  function automatic logic is_aligned(input logic [31:0] byte_addr);
    return byte_addr[1:0] == WORD_ALIGN;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU-side request ports and the memory-side bus of the
// memory access unit.
//   master : the access unit (takes requests, drives the memory bus)
//   slave  : the environment (control unit requesters plus the memory)
//
// Handshake: a requester raises fetch_req/data_req with its operands and
// holds them until the matching one-cycle ack pulse. The unit latches the
// operands when it accepts, so later changes are ignored. A req still high
// once the unit is back in IDLE is taken as a new access. Instruction,
// data_rdata and align_err are valid in the ack cycle and stay valid until
// the next access overwrites them.
interface mem_access_unit_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_ack;
  logic [31:0] Instruction;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        align_err;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Mem_data;

  modport master (
    input  fetch_req, fetch_pc, data_req, data_we, data_addr, data_wdata,
           Mem_data,
    output fetch_ack, Instruction, data_ack, data_rdata, align_err,
           Address, Write_data, MemRead, MemWrite
  );

  modport slave (
    output fetch_req, fetch_pc, data_req, data_we, data_addr, data_wdata,
           Mem_data,
    input  fetch_ack, Instruction, data_ack, data_rdata, align_err,
           Address, Write_data, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the unified instruction/data memory.
// Arbitrates between instruction fetches and loads/stores (data first),
// drives Address/Write_data/MemRead/MemWrite for MEM_LATENCY cycles and
// registers the returned word into Instruction (fetch) or data_rdata (load).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : request/ack ports and memory bus (master side)
//   dbg_state  : current FSM state, for observation only
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.master bus,
  output state_e            dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  client_e            cli_q,       cli_d;
  logic               we_q,        we_d;
  logic [31:0]        addr_q,      addr_d;
  logic [31:0]        wdata_q,     wdata_d;
  logic [31:0]        instr_q,     instr_d;
  logic [31:0]        rdata_q,     rdata_d;
  logic               align_err_q, align_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cli_q       <= CLI_FETCH;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cli_q       <= cli_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      align_err_q <= align_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cli_d       = cli_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    align_err_d = align_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.data_req || bus.fetch_req) begin
          cnt_d       = CNT_LOAD;
          align_err_d = 1'b0;
          if (bus.data_req) begin
            cli_d  = CLI_DATA;
            we_d   = bus.data_we;
            addr_d = bus.data_addr;
            if (bus.data_we) wdata_d = bus.data_wdata;
          end else begin
            cli_d  = CLI_FETCH;
            we_d   = 1'b0;
            addr_d = bus.fetch_pc;
          end
          // A misaligned access never touches memory: report it straight away.
          if (!is_aligned(addr_d)) begin
            align_err_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (cli_q == CLI_FETCH) instr_d = bus.Mem_data;
            else                    rdata_d = bus.Mem_data;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stores strobe only in the last BUSY cycle so memory is written once.
  assign bus.MemRead     = (state_q == ST_BUSY) && !we_q;
  assign bus.MemWrite    = (state_q == ST_BUSY) && we_q && (cnt_q == '0);
  assign bus.fetch_ack   = (state_q == ST_RESP) && (cli_q == CLI_FETCH);
  assign bus.data_ack    = (state_q == ST_RESP) && (cli_q == CLI_DATA);
  assign bus.Address     = addr_q;
  assign bus.Write_data  = wdata_q;
  assign bus.Instruction = instr_q;
  assign bus.data_rdata  = rdata_q;
  assign bus.align_err   = align_err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a MEM_LATENCY=1 instance (table vectors,
// corner sequences, randomized traffic against a reference model) and a
// MEM_LATENCY=3 instance (reset during a store, multi-cycle accesses).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst1, rst3, mem_init;
  always #5 clk = ~clk;

  mem_access_unit_if bus1();
  mem_access_unit_if bus3();
  state_e dbg1, dbg3;

  mem_access_unit #(.MEM_LATENCY(LAT1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1), .dbg_state(dbg1));
  mem_access_unit #(.MEM_LATENCY(LAT3), .CNT_W(4)) u_dut3 (
    .clk(clk), .reset(rst3), .bus(bus3), .dbg_state(dbg3));

  // ---------------- memory models ----------------
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  function automatic logic [31:0] init_word(input int i, input bit rich);
    if (i == 0) return 32'h2004_0005;
    if (i == 1) return 32'h0000_1026;
    if (i == 2) return 32'h0C00_0004;
    if (rich && i >= 64 && i < 128) return 32'hC0DE_0000 | 32'(i);
    return 32'h0;
  endfunction

  assign bus1.Mem_data = bus1.MemRead ? mem1[bus1.Address[9:2]] : 32'hFFFF_FFFF;
  assign bus3.Mem_data = bus3.MemRead ? mem3[bus3.Address[9:2]] : 32'hFFFF_FFFF;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_word(i, 1'b1);
        mem3[i] <= init_word(i, 1'b0);
      end
    end else begin
      if (bus1.MemWrite) mem1[bus1.Address[9:2]] <= bus1.Write_data;
      if (bus3.MemWrite) mem3[bus3.Address[9:2]] <= bus3.Write_data;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_instr, ref_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Abstract view of one access on the latency-1 unit: what it costs in
  // cycles and strobes, and what the registers must hold afterwards.
  task automatic model_access(input bit is_data, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int lat, output int reads,
                              output int writes, output logic al);
    int w;
    w = int'(addr[9:2]);
    if (addr[1:0] != 2'b00) begin
      lat = 1; reads = 0; writes = 0; al = 1'b1;
    end else begin
      lat = LAT1 + 1; al = 1'b0;
      if (is_data && we) begin
        ref_mem[w] = wdata; reads = 0; writes = 1;
      end else begin
        reads = LAT1; writes = 0;
        if (is_data) ref_rdata = ref_mem[w];
        else         ref_instr = ref_mem[w];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit sel3, input bit is_data, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit v);
    if (sel3) begin
      bus3.fetch_req = v & !is_data; bus3.data_req = v & is_data;
      bus3.data_we = we; bus3.data_addr = addr; bus3.data_wdata = wdata; bus3.fetch_pc = addr;
    end else begin
      bus1.fetch_req = v & !is_data; bus1.data_req = v & is_data;
      bus1.data_we = we; bus1.data_addr = addr; bus1.data_wdata = wdata; bus1.fetch_pc = addr;
    end
  endtask

  task automatic sample(input bit sel3, output logic mr, output logic mw, output logic fa,
                        output logic da, output logic [31:0] ins, output logic [31:0] rd,
                        output logic [31:0] a, output logic ae);
    if (sel3) begin
      mr = bus3.MemRead; mw = bus3.MemWrite; fa = bus3.fetch_ack; da = bus3.data_ack;
      ins = bus3.Instruction; rd = bus3.data_rdata; a = bus3.Address; ae = bus3.align_err;
    end else begin
      mr = bus1.MemRead; mw = bus1.MemWrite; fa = bus1.fetch_ack; da = bus1.data_ack;
      ins = bus1.Instruction; rd = bus1.data_rdata; a = bus1.Address; ae = bus1.align_err;
    end
  endtask

  // Called at a negedge with the unit in IDLE; returns at a negedge in IDLE.
  task automatic do_access(input bit sel3, input bit is_data, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int reads, output int writes,
                           output logic [31:0] waddr, output bit both,
                           output logic [31:0] ins, output logic [31:0] rd, output logic ae);
    bit done;
    logic mr, mw, fa, da;
    logic [31:0] a;
    lat = 0; reads = 0; writes = 0; waddr = '0; both = 1'b0; done = 1'b0;
    ins = '0; rd = '0; ae = 1'b0;
    drive_req(sel3, is_data, we, addr, wdata, 1'b1);
    while (!done && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
      sample(sel3, mr, mw, fa, da, ins, rd, a, ae);
      if (mr) reads++;
      if (mw) begin writes++; waddr = a; end
      if (fa && da) both = 1'b1;
      if ((is_data && da) || (!is_data && fa)) done = 1'b1;
    end
    drive_req(sel3, is_data, we, addr, wdata, 1'b0);
    check("ack_timeout", 32'(done), 32'd1);
    @(posedge clk); @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
    bit          exp_align;
    int          exp_lat;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] b2b_exp [3] = '{32'h2004_0005, 32'h0000_1026, 32'h0C00_0004};

  int lat, reads, writes, mlat, mreads, mwrites, cyc, k, dcyc, fcyc;
  logic [31:0] waddr, ins, rd;
  logic ae, mal;
  bit both;

  initial begin
    vecs[0] = '{0, 0, 32'h000, 32'h0,         32'h2004_0005, 32'h0,         0, 2, 1, 0};
    vecs[1] = '{1, 1, 32'h100, 32'hDEAD_BEEF, 32'h2004_0005, 32'h0,         0, 2, 0, 1};
    vecs[2] = '{1, 0, 32'h100, 32'h0,         32'h2004_0005, 32'hDEAD_BEEF, 0, 2, 1, 0};
    vecs[3] = '{1, 0, 32'h102, 32'h0,         32'h2004_0005, 32'hDEAD_BEEF, 1, 1, 0, 0};
    vecs[4] = '{0, 0, 32'h004, 32'h0,         32'h0000_1026, 32'hDEAD_BEEF, 0, 2, 1, 0};
    vecs[5] = '{1, 1, 32'h105, 32'h55,        32'h0000_1026, 32'hDEAD_BEEF, 1, 1, 0, 0};
    vecs[6] = '{0, 0, 32'h002, 32'h0,         32'h0000_1026, 32'hDEAD_BEEF, 1, 1, 0, 0};
    vecs[7] = '{1, 0, 32'h100, 32'h0,         32'h0000_1026, 32'hDEAD_BEEF, 0, 2, 1, 0};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i, 1'b1);
    ref_instr = '0; ref_rdata = '0;

    drive_req(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    rst1 = 1'b1; rst3 = 1'b1; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0; mem_init = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset state
    check("rst_state",  32'(dbg1), 32'(ST_IDLE));
    check("rst_instr",  bus1.Instruction, 32'h0);
    check("rst_rdata",  bus1.data_rdata, 32'h0);
    check("rst_addr",   bus1.Address, 32'h0);
    check("rst_wdata",  bus1.Write_data, 32'h0);
    check("rst_strobe", {28'h0, bus1.MemRead, bus1.MemWrite, bus1.fetch_ack, bus1.data_ack}, 32'h0);
    check("rst_align",  32'(bus1.align_err), 32'h0);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      do_access(1'b0, vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                lat, reads, writes, waddr, both, ins, rd, ae);
      model_access(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   mlat, mreads, mwrites, mal);
      check($sformatf("v%0d_lat", i),    32'(lat),    32'(vecs[i].exp_lat));
      check($sformatf("v%0d_reads", i),  32'(reads),  32'(vecs[i].exp_reads));
      check($sformatf("v%0d_writes", i), 32'(writes), 32'(vecs[i].exp_writes));
      check($sformatf("v%0d_instr", i),  ins,         vecs[i].exp_instr);
      check($sformatf("v%0d_rdata", i),  rd,          vecs[i].exp_rdata);
      check($sformatf("v%0d_align", i),  32'(ae),     32'(vecs[i].exp_align));
      if (vecs[i].exp_writes == 1) check($sformatf("v%0d_waddr", i), waddr, vecs[i].addr);
    end

    // Back-to-back fetches with fetch_req held high
    bus1.fetch_pc = 32'h0; bus1.fetch_req = 1'b1;
    cyc = 0; k = 0;
    while (k < 3 && cyc < 30) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (bus1.fetch_ack) begin
        check($sformatf("b2b%0d_cycle", k), 32'(cyc), 32'(2 + 3 * k));
        check($sformatf("b2b%0d_instr", k), bus1.Instruction, b2b_exp[k]);
        model_access(1'b0, 1'b0, bus1.fetch_pc, '0, mlat, mreads, mwrites, mal);
        k++;
        bus1.fetch_pc = 32'(4 * k);
      end
    end
    check("b2b_count", 32'(k), 32'd3);
    bus1.fetch_req = 1'b0;
    @(posedge clk); @(negedge clk);

    // Simultaneous load and fetch: data served first, acks never together
    bus1.data_req = 1'b1; bus1.data_we = 1'b0; bus1.data_addr = 32'h100;
    bus1.fetch_req = 1'b1; bus1.fetch_pc = 32'h4;
    cyc = 0; dcyc = 0; fcyc = 0; both = 1'b0;
    while (fcyc == 0 && cyc < 30) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (bus1.fetch_ack && bus1.data_ack) both = 1'b1;
      if (bus1.data_ack) begin
        dcyc = cyc;
        check("sim_rdata", bus1.data_rdata, 32'hDEAD_BEEF);
        check("sim_instr_kept", bus1.Instruction, 32'h0C00_0004);
        bus1.data_req = 1'b0;
      end
      if (bus1.fetch_ack) begin
        fcyc = cyc;
        check("sim_instr", bus1.Instruction, 32'h0000_1026);
        bus1.fetch_req = 1'b0;
      end
    end
    model_access(1'b1, 1'b0, 32'h100, '0, mlat, mreads, mwrites, mal);
    model_access(1'b0, 1'b0, 32'h4, '0, mlat, mreads, mwrites, mal);
    check("sim_data_cycle", 32'(dcyc), 32'd2);
    check("sim_fetch_cycle", 32'(fcyc), 32'd5);
    check("sim_concurrent", 32'(both), 32'd0);
    @(posedge clk); @(negedge clk);

    // Latency-3 unit: reset during the second BUSY cycle of a store
    drive_req(1'b1, 1'b1, 1'b1, 32'h104, 32'h1234_5678, 1'b1);
    writes = 0; k = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus3.MemWrite) writes++;
    end
    check("l3_busy_state", 32'(dbg3), 32'(ST_BUSY));
    rst3 = 1'b1;
    #1;
    check("l3_rst_state", 32'(dbg3), 32'(ST_IDLE));
    check("l3_rst_strobes", {30'h0, bus3.MemRead, bus3.MemWrite}, 32'h0);
    drive_req(1'b1, 1'b1, 1'b1, 32'h104, 32'h1234_5678, 1'b0);
    #1;
    rst3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus3.MemWrite) writes++;
      if (bus3.fetch_ack || bus3.data_ack) k++;
    end
    check("l3_rst_writes", 32'(writes), 32'd0);
    check("l3_rst_acks", 32'(k), 32'd0);
    do_access(1'b1, 1'b1, 1'b0, 32'h104, '0, lat, reads, writes, waddr, both, ins, rd, ae);
    check("l3_load_lat", 32'(lat), 32'(LAT3 + 1));
    check("l3_load_reads", 32'(reads), 32'(LAT3));
    check("l3_load_rdata", rd, 32'h0);
    do_access(1'b1, 1'b1, 1'b1, 32'h108, 32'hA5A5_5A5A, lat, reads, writes, waddr, both, ins, rd, ae);
    check("l3_store_lat", 32'(lat), 32'(LAT3 + 1));
    check("l3_store_writes", 32'(writes), 32'd1);
    check("l3_store_waddr", waddr, 32'h108);
    do_access(1'b1, 1'b1, 1'b0, 32'h108, '0, lat, reads, writes, waddr, both, ins, rd, ae);
    check("l3_reload_rdata", rd, 32'hA5A5_5A5A);
    do_access(1'b1, 1'b0, 1'b0, 32'h8, '0, lat, reads, writes, waddr, both, ins, rd, ae);
    check("l3_fetch_lat", 32'(lat), 32'(LAT3 + 1));
    check("l3_fetch_instr", ins, 32'h0C00_0004);
    check("l3_fetch_rdata_kept", rd, 32'hA5A5_5A5A);

    // Randomized traffic on the latency-1 unit against the reference model
    for (int i = 0; i < 60; i++) begin
      bit rd_is_data, rd_we;
      logic [31:0] upper, word, off, a, wd;
      rd_is_data = 1'($urandom_range(0, 1));
      rd_we      = rd_is_data ? 1'($urandom_range(0, 1)) : 1'b0;
      upper      = $urandom();
      word       = $urandom_range(64, 71);
      off        = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      a          = {upper[21:0], word[7:0], off[1:0]};
      wd         = $urandom();
      model_access(rd_is_data, rd_we, a, wd, mlat, mreads, mwrites, mal);
      exp_q.push_back(ref_instr);
      exp_q.push_back(ref_rdata);
      do_access(1'b0, rd_is_data, rd_we, a, wd, lat, reads, writes, waddr, both, ins, rd, ae);
      check($sformatf("r%0d_lat", i),    32'(lat),    32'(mlat));
      check($sformatf("r%0d_reads", i),  32'(reads),  32'(mreads));
      check($sformatf("r%0d_writes", i), 32'(writes), 32'(mwrites));
      check($sformatf("r%0d_align", i),  32'(ae),     32'(mal));
      check($sformatf("r%0d_instr", i),  ins,         exp_q.pop_front());
      check($sformatf("r%0d_rdata", i),  rd,          exp_q.pop_front());
      if (mwrites == 1) check($sformatf("r%0d_waddr", i), waddr, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
